// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// ID-stage hazard unit built around a per-register countdown scoreboard.
// Each architectural register (except r0) holds the number of bubbles still
// owed to a consumer of its pending result, plus a flag marking the producer
// as a load. RAW hazards stall PC/IF_ID and zero the ID controls. Taken
// jumps/branches resolved in ID squash FLUSH_SLOTS fetched instructions.
//
// Ports:
//   Clk, Reset_n             clock (rising edge), async active-low reset
//   ID_Rs/ID_Rt, ID_UsesRs/Rt  source registers of the ID instruction and read flags
//   ID_Rd, ID_RegWrite       destination and write flag of the ID instruction
//   ID_IsLoad                ID instruction is a load
//   ID_IsCtrl                ID instruction consumes registers in ID (branch, jr)
//   ID_Jump/JumpReg/BranchTaken  taken control transfer in ID
//   PCWrite, IF_ID_Write     PC / IF_ID write enables
//   ControlEn                1 = pass ID controls, 0 = bubble
//   IF_ID_Flush              clear IF_ID at next edge
//   StallCycles              saturating count of hazard-stall cycles
module hazard_scoreboard_unit #(
    parameter int unsigned AW               = 5,
    parameter int unsigned RESULT_LAT       = 2,
    parameter int unsigned FWD_EN           = 1,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned FLUSH_SLOTS      = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [AW-1:0]    ID_Rs,
    input  logic [AW-1:0]    ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [AW-1:0]    ID_Rd,
    input  logic             ID_RegWrite,
    input  logic             ID_IsLoad,
    input  logic             ID_IsCtrl,
    input  logic             ID_Jump,
    input  logic             ID_JumpReg,
    input  logic             ID_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ControlEn,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned NumRegs = 2 ** AW;
    localparam int unsigned CW      = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;
    localparam int unsigned FW      = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;

    localparam logic [CW-1:0] LatVal    = CW'(RESULT_LAT);
    // A load result is forwardable once its countdown has fallen to this value.
    localparam logic [CW-1:0] LdThresh  = CW'(RESULT_LAT - LOAD_USE_BUBBLES);
    localparam logic [FW-1:0] FlushInit = FW'(FLUSH_SLOTS - 1);
    localparam logic          FwdOn     = (FWD_EN != 0);
    localparam logic          MultiSlot = (FLUSH_SLOTS > 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    logic [CW-1:0]      r_cnt [NumRegs];
    logic [NumRegs-1:0] r_ld;
    state_e             r_state;
    logic [FW-1:0]      r_flush_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [CW-1:0] w_cnt_rs;
    logic [CW-1:0] w_cnt_rt;
    logic          w_busy_rs;
    logic          w_busy_rt;
    logic          w_hazard;
    logic          w_taken;
    logic          w_issue;

    // Hazard check always sees the pre-edge scoreboard, so an instruction that
    // reads and writes the same register waits on the older producer.
    always_comb begin
        w_cnt_rs  = r_cnt[ID_Rs];
        w_cnt_rt  = r_cnt[ID_Rt];
        w_busy_rs = ID_UsesRs && (ID_Rs != '0) && (w_cnt_rs != '0) &&
                    (ID_IsCtrl || !FwdOn || (r_ld[ID_Rs] && (w_cnt_rs > LdThresh)));
        w_busy_rt = ID_UsesRt && (ID_Rt != '0) && (w_cnt_rt != '0) &&
                    (ID_IsCtrl || !FwdOn || (r_ld[ID_Rt] && (w_cnt_rt > LdThresh)));
        w_hazard  = w_busy_rs | w_busy_rt;
        w_taken   = ID_Jump | ID_JumpReg | ID_BranchTaken;
    end

    always_comb begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ControlEn   = 1'b0;
        IF_ID_Flush = 1'b0;
        if (Reset_n) begin
            unique case (r_state)
                StFlush: begin
                    // Squash slot: keep fetching, but the ID content is dead.
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b1;
                end
                default: begin
                    if (w_hazard) begin
                        // Hold everything; jr/branch wait here for operands.
                    end else if (w_taken) begin
                        PCWrite     = 1'b1;
                        ControlEn   = 1'b1;
                        IF_ID_Flush = 1'b1;
                    end else begin
                        PCWrite     = 1'b1;
                        IF_ID_Write = 1'b1;
                        ControlEn   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_issue     = ControlEn && ID_RegWrite && (ID_Rd != '0);
    assign StallCycles = r_stall_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_cnt[i] <= '0;
            end
            r_ld        <= '0;
            r_state     <= StRun;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Scoreboard: newest producer overwrites any older entry (WAW).
            for (int i = 1; i < NumRegs; i++) begin
                if (w_issue && (ID_Rd == AW'(i))) begin
                    r_cnt[i] <= LatVal;
                    r_ld[i]  <= ID_IsLoad;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end

            unique case (r_state)
                StFlush: begin
                    if (r_flush_cnt == FW'(1)) begin
                        r_state <= StRun;
                    end
                    r_flush_cnt <= r_flush_cnt - FW'(1);
                end
                default: begin
                    if (w_hazard) begin
                        if (r_stall_cnt != '1) begin
                            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        end
                    end else if (w_taken && MultiSlot) begin
                        r_state     <= StFlush;
                        r_flush_cnt <= FlushInit;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

    localparam int LAT = 2;
    localparam int LUB = 1;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [4:0] ID_Rs, ID_Rt, ID_Rd;
    logic       ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_IsLoad, ID_IsCtrl;
    logic       ID_Jump, ID_JumpReg, ID_BranchTaken;

    logic        pc0, ifw0, ce0, fl0;
    logic [31:0] sc0;
    logic        pc1, ifw1, ce1, fl1;
    logic [1:0]  sc1;

    always #5 clk = ~clk;

    // dut0: forwarding, single flush slot, wide counter
    hazard_scoreboard_unit #(
        .AW(5), .RESULT_LAT(2), .FWD_EN(1), .LOAD_USE_BUBBLES(1), .FLUSH_SLOTS(1), .CNT_W(32)
    ) u_dut0 (
        .Clk(clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Rd(ID_Rd),
        .ID_RegWrite(ID_RegWrite), .ID_IsLoad(ID_IsLoad), .ID_IsCtrl(ID_IsCtrl),
        .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg), .ID_BranchTaken(ID_BranchTaken),
        .PCWrite(pc0), .IF_ID_Write(ifw0), .ControlEn(ce0), .IF_ID_Flush(fl0),
        .StallCycles(sc0)
    );

    // dut1: no forwarding, three flush slots, 2-bit counter to reach saturation
    hazard_scoreboard_unit #(
        .AW(5), .RESULT_LAT(2), .FWD_EN(0), .LOAD_USE_BUBBLES(1), .FLUSH_SLOTS(3), .CNT_W(2)
    ) u_dut1 (
        .Clk(clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Rd(ID_Rd),
        .ID_RegWrite(ID_RegWrite), .ID_IsLoad(ID_IsLoad), .ID_IsCtrl(ID_IsCtrl),
        .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg), .ID_BranchTaken(ID_BranchTaken),
        .PCWrite(pc1), .IF_ID_Write(ifw1), .ControlEn(ce1), .IF_ID_Flush(fl1),
        .StallCycles(sc1)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: each register remembers the cycle its newest producer
    // issued; the bubbles still owed follow from the elapsed cycle count.
    longint t = 0;
    longint iss [2][32];
    bit     ldf [2][32];
    int     fl_left [2];
    longint sc [2];
    int     fwd_c [2] = '{1, 0};
    int     fs_c [2]  = '{1, 3};
    longint scmax [2] = '{64'hFFFF_FFFF, 3};

    function automatic int rem(int c, int r);
        longint d;
        if (r == 0) return 0;
        d = LAT - (t - iss[c][r] - 1);
        return (d > 0) ? int'(d) : 0;
    endfunction

    function automatic bit busy(int c, bit u, int s);
        int rm;
        rm = rem(c, s);
        return u && (s != 0) && (rm > 0) &&
               (ID_IsCtrl || (fwd_c[c] == 0) || (ldf[c][s] && (rm > LAT - LUB)));
    endfunction

    task automatic mreset(int c);
        for (int r = 0; r < 32; r++) begin
            iss[c][r] = -1000;
            ldf[c][r] = 0;
        end
        fl_left[c] = 0;
        sc[c]      = 0;
    endtask

    task automatic model(int c, output logic [3:0] e);
        bit hz, ok;
        if (!Reset_n) begin
            e = 4'b0000;
            return;
        end
        hz = busy(c, ID_UsesRs, int'(ID_Rs)) | busy(c, ID_UsesRt, int'(ID_Rt));
        ok = 0;
        if (fl_left[c] > 0) begin
            e = 4'b1101;
            fl_left[c]--;
        end else if (hz) begin
            e = 4'b0000;
            if (sc[c] < scmax[c]) sc[c]++;
        end else if (ID_Jump || ID_JumpReg || ID_BranchTaken) begin
            e = 4'b1011;
            ok = 1;
            fl_left[c] = fs_c[c] - 1;
        end else begin
            e = 4'b1110;
            ok = 1;
        end
        if (ok && ID_RegWrite && (ID_Rd != 0)) begin
            iss[c][ID_Rd] = t;
            ldf[c][ID_Rd] = ID_IsLoad;
        end
    endtask

    // One cycle: sample mid-cycle, compare both DUTs with the model and,
    // where given (>=0), with hand-derived constants {PC,IFW,CE,FL}.
    task automatic step(input string nm, input int e0, input int e1);
        logic [3:0] m0, m1;
        #4;
        if (!Reset_n) begin
            mreset(0);
            mreset(1);
        end
        chk({nm, " stall0"}, sc0, sc[0]);
        chk({nm, " stall1"}, sc1, sc[1]);
        model(0, m0);
        model(1, m1);
        chk({nm, " out0"}, {pc0, ifw0, ce0, fl0}, m0);
        chk({nm, " out1"}, {pc1, ifw1, ce1, fl1}, m1);
        if (e0 >= 0) chk({nm, " const0"}, {pc0, ifw0, ce0, fl0}, e0[3:0]);
        if (e1 >= 0) chk({nm, " const1"}, {pc1, ifw1, ce1, fl1}, e1[3:0]);
        t++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       us, ut, rw, ld, ctrl, j, jr, br;
        int         exp;
    } vec_t;

    function automatic vec_t mk(int rs, int us, int rt, int ut, int rd, int rw, int ld,
                                int ctrl, int j, int jr, int br, int exp);
        vec_t v;
        v.rs = 5'(rs); v.us = us[0]; v.rt = 5'(rt); v.ut = ut[0];
        v.rd = 5'(rd); v.rw = rw[0]; v.ld = ld[0]; v.ctrl = ctrl[0];
        v.j = j[0]; v.jr = jr[0]; v.br = br[0]; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ID_Rs = v.rs; ID_UsesRs = v.us; ID_Rt = v.rt; ID_UsesRt = v.ut;
        ID_Rd = v.rd; ID_RegWrite = v.rw; ID_IsLoad = v.ld; ID_IsCtrl = v.ctrl;
        ID_Jump = v.j; ID_JumpReg = v.jr; ID_BranchTaken = v.br;
    endtask

    vec_t tbl[$];
    vec_t nop;

    initial begin
        // Expected codes for dut0: 14 = run, 0 = stall, 11 = taken
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14);
        tbl.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 14));   // lw r5
        tbl.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0));    // add r6,r5: load-use
        tbl.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 14));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 14));   // add r2
        tbl.push_back(mk(2, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 14));   // add r7,r2: forwarded
        tbl.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 14));   // add r8
        tbl.push_back(mk(8, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));    // beq r8,r0 taken
        tbl.push_back(mk(8, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(8, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 11));
        tbl.push_back(nop);
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 14));   // write r0
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 14));   // read r0
        tbl.push_back(mk(0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 14));  // add r10
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 14));  // Rs=r10 unused
        tbl.push_back(mk(0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0));   // ctrl reads r10
        tbl.push_back(mk(0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0, 14));
        tbl.push_back(mk(0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 14));   // lw r9
        tbl.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 14));   // add r9 (WAW)
        tbl.push_back(mk(9, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 14));  // no load-use now
        tbl.push_back(mk(0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 14));  // add r12
        tbl.push_back(mk(12, 1, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0));  // ctrl r12 -> r12
        tbl.push_back(mk(12, 1, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(12, 1, 0, 0, 12, 1, 0, 1, 0, 0, 0, 14));
        tbl.push_back(mk(12, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));   // new entry counts
        tbl.push_back(nop);

        Reset_n = 1'b0;
        apply(nop);
        mreset(0);
        mreset(1);
        @(posedge clk);
        #1;
        step("reset", 0, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            step($sformatf("tbl%0d", i), tbl[i].exp, -1);
        end
        chk("tbl stall total", sc0, 64'd7);

        // No-forwarding stall and three-slot flush on dut1
        Reset_n = 1'b0;
        apply(nop);
        step("rst2", 0, 0);
        Reset_n = 1'b1;
        apply(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        step("nf add r3", -1, 14);
        apply(mk(3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
        step("nf sub s1", -1, 0);
        step("nf sub s2", -1, 0);
        step("nf sub go", -1, 14);
        chk("nf stall total", sc1, 64'd2);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("j take", -1, 11);
        apply(mk(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("flush2", -1, 13);
        step("flush3", -1, 13);
        apply(nop);
        step("after flush", -1, 14);
        chk("flush stall total", sc1, 64'd2);

        // Asynchronous reset during a stall clears the scoreboard at once
        apply(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        step("mr add r3", 14, 14);
        apply(mk(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step("mr stall", 0, 0);
        Reset_n = 1'b0;
        #1;
        chk("mr outs0", {pc0, ifw0, ce0, fl0}, 64'd0);
        chk("mr outs1", {pc1, ifw1, ce1, fl1}, 64'd0);
        chk("mr stall0", sc0, 64'd0);
        mreset(0);
        mreset(1);
        #1;
        Reset_n = 1'b1;
        step("mr resume", 14, 14);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Reset_n        = ($urandom_range(0, 99) != 0);
            ID_Rs          = 5'($urandom_range(0, 7));
            ID_Rt          = 5'($urandom_range(0, 7));
            ID_UsesRs      = 1'($urandom_range(0, 1));
            ID_UsesRt      = 1'($urandom_range(0, 1));
            ID_Rd          = 5'($urandom_range(0, 7));
            ID_RegWrite    = ($urandom_range(0, 9) < 7);
            ID_IsLoad      = ($urandom_range(0, 9) < 3);
            ID_IsCtrl      = ($urandom_range(0, 9) < 2);
            ID_Jump        = ($urandom_range(0, 19) == 0);
            ID_JumpReg     = ($urandom_range(0, 19) == 0);
            ID_BranchTaken = ($urandom_range(0, 19) == 0);
            step("rand", -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
